multi_alarm_core: RTL
=====================

# multi_alarm_core

Parametrised successor to the single-alarm compute block: one 12-hour time-of-day counter, `N_ALARMS` independently settable and armable alarm registers, a single ringer state machine with snooze and auto-timeout, and the 11-bit display mux. It sits between the front-panel button synchroniser and the display/speaker drivers. All state is on one clock, advanced by a one-cycle `TICK` enable.

## Interface
Parameters:
- `N_ALARMS`, 4: number of alarm channels, range 1..16.
- `TICKS_PER_MIN`, 60: `TICK` pulses per minute.
- `SNOOZE_MINS`, 5: snooze length in minutes, range 1..15.
- `RING_MINS`, 10: auto-silence after this many minutes of ringing, range 1..15.

Ports:
- Clock and reset: one clock, `CLK`; reset `RESETN` is asynchronous and active-low.
- `CLK`, input, 1: system clock.
- `RESETN`, input, 1: asynchronous active-low reset.
- `TICK`, input, 1: one-cycle timebase enable.
- `SET_TIME`, input, 1: level; time edit mode.
- `ALARM`, input, 1: level; alarm edit/view mode, overrides `SET_TIME`.
- `SEL`, input, clog2(`N_ALARMS`) (min 1): alarm channel edited and displayed.
- `HRS`, `MINS`, input, 1 each: synchronised buttons; a rising edge increments.
- `ARM`, input, `N_ALARMS`: per-channel alarm enable.
- `TOGGLE_SWITCH`, input, 1: master ringer enable; low forces silence.
- `SNOOZE`, input, 1: synchronised button; a rising edge snoozes.
- `DISPLAY`, output, 11: {AM_PM, HRS[3:0], MINS[5:0]}.
- `SPEAKER_OUT`, output, 1: high while ringing.
- `RING_ID`, output, clog2(`N_ALARMS`): channel that caused the current ring.

## Operation
- Time format: hours 1..12, minutes 0..59, AM_PM (0 = AM).
- Reset: time and all alarms are 12:00 AM. Prescaler = 0, FSM = IDLE, `SPEAKER_OUT` = 0, `RING_ID` = 0, `DISPLAY` = 12:00 AM.
- Run mode (`SET_TIME` = 0, `ALARM` = 0):
  - Each `TICK` increments the prescaler; at `TICKS_PER_MIN`-1 it wraps and a minute advance occurs.
  - Minute 59→0 carries into hours. Hour 11→12 toggles AM_PM; hour 12→1 does not.
- Time edit (`SET_TIME` = 1, `ALARM` = 0):
  - Prescaler is held at 0 and `TICK` is ignored.
  - `HRS` edge advances the hour with the same AM_PM rule.
  - `MINS` edge advances the minute; 59→0 does not carry.
- Alarm edit (`ALARM` = 1): `HRS`/`MINS` edges edit alarm[`SEL`] with the same rules. Time keeps running.
- `DISPLAY` shows alarm[`SEL`] when `ALARM` = 1, otherwise time.
- Match: channel i matches when `ARM`[i] = 1 and alarm[i] equals the time (all 11 bits).
  - A trigger is a rising edge of the OR of all matches while `TOGGLE_SWITCH` = 1.
  - The lowest matching index is latched into `RING_ID`.
- Ringer FSM:
  - IDLE → RINGING on trigger. Load the ring-minute counter with `RING_MINS`.
  - RINGING → IDLE when `TOGGLE_SWITCH` = 0, or when the ring-minute counter reaches 0. It decrements on each minute advance.
  - RINGING → SNOOZED on a `SNOOZE` edge. Load the snooze counter with `SNOOZE_MINS`.
  - SNOOZED → RINGING when the snooze counter reaches 0 (decrements per minute advance). Reload `RING_MINS`.
  - SNOOZED → IDLE when `TOGGLE_SWITCH` = 0.
  - SNOOZED → RINGING on a new trigger: update `RING_ID` and reload `RING_MINS`.
  - A trigger while RINGING is ignored and `RING_ID` is unchanged.
- `SPEAKER_OUT` = 1 only in RINGING.
- Edits that create a match in the current minute trigger the ringer (edge rule applies).

## Timing
- All outputs are registered.
- `DISPLAY` updates 1 cycle after a mode, `SEL` or value change.
- Button edge to value change: 1 cycle. Edge to visible `DISPLAY`: 2 cycles.
- Minute advance to `SPEAKER_OUT` high: 2 cycles (compare register + FSM).
- `TOGGLE_SWITCH` low to `SPEAKER_OUT` low: 1 cycle.
- A minute advance and an edit in the same cycle cannot collide, because the prescaler is frozen in time edit.
- A `SNOOZE` edge and a counter expiry in the same cycle: `SNOOZE` wins.
- Reset mid-ring: `SPEAKER_OUT` drops asynchronously.

## Configuration
- `MULTI_ALARM_SNOOZE_EN` defined: SNOOZED state, snooze counter and `SNOOZE` handling are present as above.
- Not defined: the `SNOOZE` port remains but is ignored, the SNOOZED state and its counter are removed, and RINGING exits only on `TOGGLE_SWITCH` low or timeout.

## Structure
- Package `alarm_pkg` holds:
  - The time-of-day struct (am_pm, hrs[3:0], mins[5:0]) and the 11-bit width constant.
  - The reset time constant (12:00 AM).
  - The FSM state enum (IDLE, RINGING, SNOOZED).
  - The increment functions for hours and minutes.
- One sub-module, `time_counter`: prescaler plus hour/minute/AM_PM registers with run/edit control, outputting a minute-advance strobe. It is instantiated once.
- Alarm registers, match logic, FSM and display mux live in the top level.

## Test plan
- Reset, then 60×`TICKS_PER_MIN` ticks in run mode → `DISPLAY` = 1:00 AM. After 12 h of ticks → 12:00 PM, AM_PM = 1.
- `SET_TIME` = 1 with 59 `MINS` edges and one more → minutes 59 then 0, hour unchanged. `TICK`s during edit → no change.
- Set alarm[2] = 6:30 AM with `ARM` = 4'b0100, run to 6:30 AM → `SPEAKER_OUT` = 1 two cycles after the minute advance, `RING_ID` = 2. After `RING_MINS` minutes → `SPEAKER_OUT` = 0.
- Alarms 1 and 3 both at 7:00 AM, both armed → `RING_ID` = 1. Drop `TOGGLE_SWITCH` → `SPEAKER_OUT` = 0 next cycle.
- With `MULTI_ALARM_SNOOZE_EN`: `SNOOZE` edge while ringing at 6:30 → silent until 6:35, then rings again. Without the macro → `SNOOZE` has no effect.
- Assert `RESETN` low while ringing → `SPEAKER_OUT` = 0 immediately and `DISPLAY` = 12:00 AM.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and helpers for the multi-alarm clock.
//   tod_t        - packed time of day {am_pm, hrs[3:0], mins[5:0]}, TIME_W bits
//   RESET_TIME   - 12:00 AM
//   ring_state_t - ringer FSM states
//   inc_hrs / inc_mins / adv_minute / edit_tod - time arithmetic on tod_t
package alarm_pkg;

    localparam int TIME_W = 11;

    typedef struct packed {
        logic       am_pm;
        logic [3:0] hrs;
        logic [5:0] mins;
    } tod_t;

    localparam tod_t RESET_TIME = '{am_pm: 1'b0, hrs: 4'd12, mins: 6'd0};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } ring_state_t;

    // Hours run 12,1..11; AM/PM flips on 11 -> 12, not on 12 -> 1.
    function automatic tod_t inc_hrs(input tod_t t);
        tod_t r;
        r = t;
        if (t.hrs == 4'd12) r.hrs = 4'd1;
        else                r.hrs = t.hrs + 4'd1;
        if (t.hrs == 4'd11) r.am_pm = ~t.am_pm;
        return r;
    endfunction

    // Edit-style minute increment: wraps 59 -> 0 without touching hours.
    function automatic tod_t inc_mins(input tod_t t);
        tod_t r;
        r = t;
        r.mins = (t.mins == 6'd59) ? 6'd0 : t.mins + 6'd1;
        return r;
    endfunction

    // Run-mode minute advance: 59 -> 0 carries into hours.
    function automatic tod_t adv_minute(input tod_t t);
        tod_t r;
        r = t;
        if (t.mins == 6'd59) begin
            r = inc_hrs(t);
            r.mins = 6'd0;
        end else begin
            r.mins = t.mins + 6'd1;
        end
        return r;
    endfunction

    // Button edits; both buttons in one cycle apply both increments.
    function automatic tod_t edit_tod(input tod_t t, input logic h, input logic m);
        tod_t r;
        r = t;
        if (h) r = inc_hrs(r);
        if (m) r = inc_mins(r);
        return r;
    endfunction

endpackage

// File: rtl/time_counter.sv
// time_counter: prescaler plus 12-hour time-of-day register.
//   clk, rst_n     - clock, async active-low reset
//   tick           - timebase enable, counted by the prescaler in run mode
//   set_time/alarm - mode levels; time edit only when set_time & ~alarm
//   hrs_edge/mins_edge - one-cycle button edges
//   tod            - current time of day
//   min_adv        - one-cycle strobe, high the cycle after a run-mode minute advance
module time_counter
    import alarm_pkg::*;
#(
    parameter int TICKS_PER_MIN = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic set_time,
    input  logic alarm,
    input  logic hrs_edge,
    input  logic mins_edge,
    output tod_t tod,
    output logic min_adv
);

    localparam int PW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MIN - 1);

    logic [PW-1:0] presc;
    logic          edit;

    assign edit = set_time & ~alarm;

    // Edit mode freezes the prescaler, so a minute advance can never
    // coincide with a button edit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            tod     <= RESET_TIME;
            min_adv <= 1'b0;
        end else begin
            min_adv <= 1'b0;
            if (edit) begin
                presc <= '0;
                tod   <= edit_tod(tod, hrs_edge, mins_edge);
            end else if (tick) begin
                if (presc == PRESC_LAST) begin
                    presc   <= '0;
                    tod     <= adv_minute(tod);
                    min_adv <= 1'b1;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/multi_alarm_core.sv
// multi_alarm_core: 12-hour clock with N_ALARMS armable alarms, one ringer
// FSM with auto-timeout (and optional snooze), and an 11-bit display mux.
//   CLK, RESETN   - clock, async active-low reset
//   TICK          - timebase enable
//   SET_TIME      - time edit mode; ALARM - alarm edit/view mode (overrides)
//   SEL           - alarm channel edited/displayed
//   HRS, MINS     - synchronised buttons, rising edge increments
//   ARM           - per-channel alarm enable
//   TOGGLE_SWITCH - master ringer enable, low silences
//   SNOOZE        - synchronised button, rising edge snoozes
//   DISPLAY       - {AM_PM, HRS, MINS} of alarm[SEL] or time
//   SPEAKER_OUT   - high while ringing; RING_ID - channel that triggered
// Optional feature: define MULTI_ALARM_SNOOZE_EN to build the SNOOZED state.
// Without it the SNOOZE input is ignored.
module multi_alarm_core
    import alarm_pkg::*;
#(
    parameter int N_ALARMS      = 4,
    parameter int TICKS_PER_MIN = 60,
    parameter int SNOOZE_MINS   = 5,
    parameter int RING_MINS     = 10,
    localparam int SW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                TICK,
    input  logic                SET_TIME,
    input  logic                ALARM,
    input  logic [SW-1:0]       SEL,
    input  logic                HRS,
    input  logic                MINS,
    input  logic [N_ALARMS-1:0] ARM,
    input  logic                TOGGLE_SWITCH,
    input  logic                SNOOZE,
    output logic [TIME_W-1:0]   DISPLAY,
    output logic                SPEAKER_OUT,
    output logic [SW-1:0]       RING_ID
);

    localparam logic [3:0] RING_LOAD   = 4'(RING_MINS);
    localparam logic [3:0] SNOOZE_LOAD = 4'(SNOOZE_MINS);

    // Button edge detection
    logic hrs_q, mins_q, hrs_edge, mins_edge;
    assign hrs_edge  = HRS  & ~hrs_q;
    assign mins_edge = MINS & ~mins_q;

    tod_t tod;
    logic min_adv;

    time_counter #(.TICKS_PER_MIN(TICKS_PER_MIN)) u_time (
        .clk       (CLK),
        .rst_n     (RESETN),
        .tick      (TICK),
        .set_time  (SET_TIME),
        .alarm     (ALARM),
        .hrs_edge  (hrs_edge),
        .mins_edge (mins_edge),
        .tod       (tod),
        .min_adv   (min_adv)
    );

    // Alarm registers and compare
    tod_t [N_ALARMS-1:0] alarms;
    tod_t                sel_alarm;
    logic [N_ALARMS-1:0] match, match_q;
    logic                any_q, any_prev, trigger;
    logic [SW-1:0]       first_id;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < N_ALARMS; i++) alarms[i] <= RESET_TIME;
        end else if (ALARM) begin
            for (int i = 0; i < N_ALARMS; i++)
                if (SEL == SW'(i)) alarms[i] <= edit_tod(alarms[i], hrs_edge, mins_edge);
        end
    end

    // SEL values beyond N_ALARMS-1 show 12:00 AM rather than an undefined slot.
    always_comb begin
        sel_alarm = RESET_TIME;
        for (int i = 0; i < N_ALARMS; i++)
            if (SEL == SW'(i)) sel_alarm = alarms[i];
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < N_ALARMS; i++)
            match[i] = ARM[i] && (alarms[i] == tod);
    end

    // Lowest matching index wins.
    always_comb begin
        first_id = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--)
            if (match_q[i]) first_id = SW'(i);
    end

    assign any_q   = |match_q;
    // Edge of the OR, so a match that is already standing never re-triggers
    // when the toggle switch is turned back on.
    assign trigger = any_q & ~any_prev & TOGGLE_SWITCH;

    // Ringer FSM
    ring_state_t state, state_d;
    logic [3:0]  ring_cnt, ring_cnt_d;
    logic [SW-1:0] ring_id_d;

`ifdef MULTI_ALARM_SNOOZE_EN
    logic       snooze_q, snooze_edge;
    logic [3:0] snz_cnt, snz_cnt_d;
    assign snooze_edge = SNOOZE & ~snooze_q;
`else
    logic unused_snooze;
    assign unused_snooze = ^{SNOOZE, SNOOZE_LOAD};
`endif

    always_comb begin
        state_d    = state;
        ring_cnt_d = ring_cnt;
        ring_id_d  = RING_ID;
`ifdef MULTI_ALARM_SNOOZE_EN
        snz_cnt_d  = snz_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (trigger) begin
                    state_d    = ST_RINGING;
                    ring_cnt_d = RING_LOAD;
                    ring_id_d  = first_id;
                end
            end
            ST_RINGING: begin
                // Triggers are ignored here; snooze beats a same-cycle expiry.
                if (!TOGGLE_SWITCH) begin
                    state_d = ST_IDLE;
`ifdef MULTI_ALARM_SNOOZE_EN
                end else if (snooze_edge) begin
                    state_d   = ST_SNOOZED;
                    snz_cnt_d = SNOOZE_LOAD;
`endif
                end else if (min_adv) begin
                    ring_cnt_d = ring_cnt - 4'd1;
                    if (ring_cnt <= 4'd1) begin
                        state_d    = ST_IDLE;
                        ring_cnt_d = 4'd0;
                    end
                end
            end
`ifdef MULTI_ALARM_SNOOZE_EN
            ST_SNOOZED: begin
                if (!TOGGLE_SWITCH) begin
                    state_d = ST_IDLE;
                end else if (trigger) begin
                    state_d    = ST_RINGING;
                    ring_cnt_d = RING_LOAD;
                    ring_id_d  = first_id;
                end else if (min_adv) begin
                    snz_cnt_d = snz_cnt - 4'd1;
                    if (snz_cnt <= 4'd1) begin
                        state_d    = ST_RINGING;
                        ring_cnt_d = RING_LOAD;
                        snz_cnt_d  = 4'd0;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            hrs_q       <= 1'b0;
            mins_q      <= 1'b0;
            match_q     <= '0;
            any_prev    <= 1'b0;
            state       <= ST_IDLE;
            ring_cnt    <= 4'd0;
            RING_ID     <= '0;
            SPEAKER_OUT <= 1'b0;
            DISPLAY     <= RESET_TIME;
`ifdef MULTI_ALARM_SNOOZE_EN
            snooze_q    <= 1'b0;
            snz_cnt     <= 4'd0;
`endif
        end else begin
            hrs_q       <= HRS;
            mins_q      <= MINS;
            match_q     <= match;
            any_prev    <= any_q;
            state       <= state_d;
            ring_cnt    <= ring_cnt_d;
            RING_ID     <= ring_id_d;
            SPEAKER_OUT <= (state_d == ST_RINGING);
            DISPLAY     <= ALARM ? sel_alarm : tod;
`ifdef MULTI_ALARM_SNOOZE_EN
            snooze_q    <= SNOOZE;
            snz_cnt     <= snz_cnt_d;
`endif
        end
    end

endmodule
